// File: rtl/aurora_pkg.sv
// Shared types and constants for the Aurora path controller.
package aurora_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_SEQ_W      = 32;
    localparam int DEF_LOOP_DEPTH = 16;
    localparam int DEF_CNT_W      = 32;

    typedef enum logic [1:0] {
        ST_HOST = 2'd0,
        ST_SEQ  = 2'd1,
        ST_LOOP = 2'd2
    } tx_state_e;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/loop_fifo.sv
// First-word-fall-through synchronous FIFO; a write into a full FIFO is
// accepted only when a read frees a slot in the same cycle.
module loop_fifo
    import aurora_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_wr, do_rd;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/aurora_path_ctrl.sv
// Host <-> Aurora glue: TX sequence insert, RX sequence strip, frame-aligned loopback.
// Define AURORA_SEQ_CHECK_EN to add the stat_seq_gaps counter.
module aurora_path_ctrl
    import aurora_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SEQ_W      = DEF_SEQ_W,
    parameter int LOOP_DEPTH = DEF_LOOP_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_aresetn,
    input  logic              s_host_tvalid,
    input  logic [DATA_W-1:0] s_host_tdata,
    input  logic              s_host_tlast,
    output logic              s_host_tready,
    output logic              m_aur_tvalid,
    output logic [DATA_W-1:0] m_aur_tdata,
    output logic              m_aur_tlast,
    input  logic              m_aur_tready,
    input  logic              s_aur_tvalid,
    input  logic [DATA_W-1:0] s_aur_tdata,
    input  logic              s_aur_tlast,
    output logic              m_host_tvalid,
    output logic [DATA_W-1:0] m_host_tdata,
    output logic              m_host_tlast,
    input  logic              ctrl_loopback,
    input  logic              ctrl_seq_en,
    output logic              stat_loop_active,
    output logic [CNT_W-1:0]  stat_tx_frames,
    output logic [CNT_W-1:0]  stat_rx_frames,
    output logic [SEQ_W-1:0]  stat_rx_seq,
    output logic              stat_loop_ovf,
    output logic              stat_runt
`ifdef AURORA_SEQ_CHECK_EN
    ,
    output logic [CNT_W-1:0]  stat_seq_gaps
`endif
);

    localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    tx_state_e         state_q, state_d;
    logic              run_q;
    logic [SEQ_W-1:0]  seq_q, rx_seq_q;
    logic [CNT_W-1:0]  tx_frames_q, rx_frames_q;
    logic              tx_in_frame_q, tx_en_q, tx_seq_en;
    logic              rx_in_frame_q, rx_en_q, rx_seq_en;
    logic              hold_valid_q;
    logic [DATA_W-1:0] hold_q, host_data_q;
    logic              host_valid_q, host_last_q;
    logic              ovf_q, runt_q, lp_cap_q, lp_drop_q;
    logic              loop_active, lp_take, ovf_evt, strip_evt;
    logic              fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [DATA_W:0]   fifo_rd_data;

    // Mode bits are latched on the first beat of a frame and held until its tlast.
    assign tx_seq_en   = tx_in_frame_q ? tx_en_q : ctrl_seq_en;
    assign rx_seq_en   = rx_in_frame_q ? rx_en_q : ctrl_seq_en;
    assign loop_active = (state_q == ST_LOOP);
    assign lp_take     = s_aur_tvalid && (rx_in_frame_q ? lp_cap_q : loop_active);
    assign ovf_evt     = lp_take && !lp_drop_q && fifo_full && !fifo_rd;
    assign fifo_wr     = lp_take && !lp_drop_q && !ovf_evt;
    assign strip_evt   = s_aur_tvalid && rx_seq_en && s_aur_tlast && hold_valid_q;

    loop_fifo #(.WIDTH(DATA_W + 1), .DEPTH(LOOP_DEPTH)) u_loop_fifo (
        .clk_i     (m_axis_aclk),
        .rst_ni    (m_axis_aresetn),
        .wr_en_i   (fifo_wr),
        .wr_data_i ({s_aur_tlast, s_aur_tdata}),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // run_q keeps every stream output at zero while reset is held.
    always_comb begin
        state_d       = state_q;
        m_aur_tvalid  = 1'b0;
        m_aur_tdata   = '0;
        m_aur_tlast   = 1'b0;
        s_host_tready = 1'b0;
        fifo_rd       = 1'b0;
        if (run_q) begin
            case (state_q)
                ST_HOST: begin
                    if (!tx_in_frame_q && ctrl_loopback) begin
                        state_d = ST_LOOP;
                    end else begin
                        m_aur_tvalid  = s_host_tvalid;
                        m_aur_tdata   = s_host_tdata;
                        m_aur_tlast   = s_host_tlast && !tx_seq_en;
                        s_host_tready = m_aur_tready;
                        if (s_host_tvalid && m_aur_tready && s_host_tlast && tx_seq_en)
                            state_d = ST_SEQ;
                    end
                end
                ST_SEQ: begin
                    m_aur_tvalid = 1'b1;
                    m_aur_tdata  = DATA_W'(seq_q);
                    m_aur_tlast  = 1'b1;
                    if (m_aur_tready) state_d = ctrl_loopback ? ST_LOOP : ST_HOST;
                end
                ST_LOOP: begin
                    m_aur_tvalid = !fifo_empty;
                    fifo_rd      = m_aur_tready && !fifo_empty;
                    if (!fifo_empty) {m_aur_tlast, m_aur_tdata} = fifo_rd_data;
                    // An empty FIFO with no frame being captured is also a safe boundary.
                    if (!ctrl_loopback && ((fifo_rd && fifo_rd_data[DATA_W]) ||
                                           (fifo_empty && !lp_cap_q && !lp_take)))
                        state_d = ST_HOST;
                end
                default: state_d = ST_HOST;
            endcase
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            run_q         <= 1'b0;
            state_q       <= ST_HOST;
            seq_q         <= '0;
            tx_in_frame_q <= 1'b0;
            tx_en_q       <= 1'b0;
            tx_frames_q   <= '0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            if (s_host_tvalid && s_host_tready) begin
                if (!tx_in_frame_q) tx_en_q <= ctrl_seq_en;
                tx_in_frame_q <= !s_host_tlast;
            end
            if (state_q == ST_SEQ && m_aur_tready) begin
                seq_q       <= seq_q + SEQ_ONE;
                tx_frames_q <= tx_frames_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            rx_in_frame_q <= 1'b0;
            rx_en_q       <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_q        <= '0;
            host_valid_q  <= 1'b0;
            host_data_q   <= '0;
            host_last_q   <= 1'b0;
            rx_seq_q      <= '0;
            rx_frames_q   <= '0;
            ovf_q         <= 1'b0;
            runt_q        <= 1'b0;
            lp_cap_q      <= 1'b0;
            lp_drop_q     <= 1'b0;
        end else begin
            host_valid_q <= 1'b0;
            if (ovf_evt) ovf_q <= 1'b1;
            if (s_aur_tvalid) begin
                if (!rx_in_frame_q) rx_en_q <= ctrl_seq_en;
                rx_in_frame_q <= !s_aur_tlast;
                lp_cap_q      <= lp_take && !s_aur_tlast;
                lp_drop_q     <= (lp_drop_q || ovf_evt) && !s_aur_tlast;
                if (!rx_seq_en) begin
                    host_valid_q <= 1'b1;
                    host_data_q  <= s_aur_tdata;
                    host_last_q  <= s_aur_tlast;
                    if (s_aur_tlast) rx_frames_q <= rx_frames_q + CNT_ONE;
                end else if (s_aur_tlast) begin
                    // The tlast beat is the sequence word; the held beat closes the frame.
                    hold_valid_q <= 1'b0;
                    if (hold_valid_q) begin
                        host_valid_q <= 1'b1;
                        host_data_q  <= hold_q;
                        host_last_q  <= 1'b1;
                        rx_seq_q     <= s_aur_tdata[SEQ_W-1:0];
                        rx_frames_q  <= rx_frames_q + CNT_ONE;
                    end else begin
                        runt_q <= 1'b1;
                    end
                end else begin
                    hold_q       <= s_aur_tdata;
                    hold_valid_q <= 1'b1;
                    if (hold_valid_q) begin
                        host_valid_q <= 1'b1;
                        host_data_q  <= hold_q;
                        host_last_q  <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef AURORA_SEQ_CHECK_EN
    logic             seq_seen_q;
    logic [CNT_W-1:0] seq_gaps_q;

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            seq_seen_q <= 1'b0;
            seq_gaps_q <= '0;
        end else if (strip_evt) begin
            seq_seen_q <= 1'b1;
            if (seq_seen_q && (s_aur_tdata[SEQ_W-1:0] != rx_seq_q + SEQ_ONE))
                seq_gaps_q <= seq_gaps_q + CNT_ONE;
        end
    end

    assign stat_seq_gaps = seq_gaps_q;
`endif

    assign m_host_tvalid    = host_valid_q;
    assign m_host_tdata     = host_data_q;
    assign m_host_tlast     = host_last_q;
    assign stat_loop_active = loop_active;
    assign stat_tx_frames   = tx_frames_q;
    assign stat_rx_frames   = rx_frames_q;
    assign stat_rx_seq      = rx_seq_q;
    assign stat_loop_ovf    = ovf_q;
    assign stat_runt        = runt_q;

endmodule

// File: tb/tb_aurora_path_ctrl.sv
// Directed bench for aurora_path_ctrl (DATA_W=32, SEQ_W=8, LOOP_DEPTH=16).
module tb_aurora_path_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_host_tvalid, s_host_tlast, s_host_tready;
    logic [31:0] s_host_tdata;
    logic        m_aur_tvalid, m_aur_tlast, m_aur_tready;
    logic [31:0] m_aur_tdata;
    logic        s_aur_tvalid, s_aur_tlast;
    logic [31:0] s_aur_tdata;
    logic        m_host_tvalid, m_host_tlast;
    logic [31:0] m_host_tdata;
    logic        ctrl_loopback, ctrl_seq_en;
    logic        stat_loop_active, stat_loop_ovf, stat_runt;
    logic [31:0] stat_tx_frames, stat_rx_frames;
    logic [7:0]  stat_rx_seq;
`ifdef AURORA_SEQ_CHECK_EN
    logic [31:0] stat_seq_gaps;
`endif

    int checks = 0;
    int errors = 0;

    logic [32:0] aur_q[$], exp_aur_q[$];
    logic [32:0] host_q[$], exp_host_q[$];

    aurora_path_ctrl #(.DATA_W(32), .SEQ_W(8), .LOOP_DEPTH(16), .CNT_W(32)) dut (
        .m_axis_aclk      (clk),
        .m_axis_aresetn   (rst_n),
        .s_host_tvalid    (s_host_tvalid),
        .s_host_tdata     (s_host_tdata),
        .s_host_tlast     (s_host_tlast),
        .s_host_tready    (s_host_tready),
        .m_aur_tvalid     (m_aur_tvalid),
        .m_aur_tdata      (m_aur_tdata),
        .m_aur_tlast      (m_aur_tlast),
        .m_aur_tready     (m_aur_tready),
        .s_aur_tvalid     (s_aur_tvalid),
        .s_aur_tdata      (s_aur_tdata),
        .s_aur_tlast      (s_aur_tlast),
        .m_host_tvalid    (m_host_tvalid),
        .m_host_tdata     (m_host_tdata),
        .m_host_tlast     (m_host_tlast),
        .ctrl_loopback    (ctrl_loopback),
        .ctrl_seq_en      (ctrl_seq_en),
        .stat_loop_active (stat_loop_active),
        .stat_tx_frames   (stat_tx_frames),
        .stat_rx_frames   (stat_rx_frames),
        .stat_rx_seq      (stat_rx_seq),
        .stat_loop_ovf    (stat_loop_ovf),
        .stat_runt        (stat_runt)
`ifdef AURORA_SEQ_CHECK_EN
        ,
        .stat_seq_gaps    (stat_seq_gaps)
`endif
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Monitor: record accepted m_aur beats and every m_host beat
    always @(negedge clk) begin
        #2;
        if (m_aur_tvalid && m_aur_tready) aur_q.push_back({m_aur_tlast, m_aur_tdata});
        if (m_host_tvalid) host_q.push_back({m_host_tlast, m_host_tdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_aur(input string tag);
        check({tag, "_len"}, aur_q.size(), exp_aur_q.size());
        while (aur_q.size() > 0 && exp_aur_q.size() > 0)
            check(tag, aur_q.pop_front(), exp_aur_q.pop_front());
        aur_q.delete();
        exp_aur_q.delete();
    endtask

    task automatic check_host(input string tag);
        check({tag, "_len"}, host_q.size(), exp_host_q.size());
        while (host_q.size() > 0 && exp_host_q.size() > 0)
            check(tag, host_q.pop_front(), exp_host_q.pop_front());
        host_q.delete();
        exp_host_q.delete();
    endtask

    task automatic exp_aur(input logic l, input logic [31:0] d);
        exp_aur_q.push_back({l, d});
    endtask

    task automatic exp_host(input logic l, input logic [31:0] d);
        exp_host_q.push_back({l, d});
    endtask

    // Drivers
    task automatic host_beat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        s_host_tvalid = 1'b1;
        s_host_tdata  = d;
        s_host_tlast  = l;
        #2;
        while (!s_host_tready && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL host_beat_timeout observed=no_tready expected=tready");
        end
    endtask

    task automatic host_idle();
        @(negedge clk);
        s_host_tvalid = 1'b0;
        s_host_tlast  = 1'b0;
    endtask

    task automatic rx_beat(input logic [31:0] d, input logic l);
        @(negedge clk);
        s_aur_tvalid = 1'b1;
        s_aur_tdata  = d;
        s_aur_tlast  = l;
    endtask

    task automatic rx_idle();
        @(negedge clk);
        s_aur_tvalid = 1'b0;
        s_aur_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] a_w, b_w, c_w, e_w, d0, d1, d2, x0, x1, v0, v1, m0, r0, s0;

    initial begin
        a_w = 32'hA000_0001; b_w = 32'hB000_0002; c_w = 32'hC000_0003; e_w = 32'hE000_0004;
        d0 = 32'hD000_0000; d1 = 32'hD000_0001; d2 = 32'hD000_0002;
        x0 = 32'h1234_5678; x1 = 32'h9ABC_DEF0;
        v0 = 32'h5A5A_0001; v1 = 32'h55AA_0014;
        m0 = 32'h0BAD_0000; r0 = 32'h0BAD_0001; s0 = 32'h0000_00EE;

        rst_n = 1'b0;
        s_host_tvalid = 1'b0; s_host_tdata = '0; s_host_tlast = 1'b0;
        s_aur_tvalid = 1'b0;  s_aur_tdata = '0;  s_aur_tlast = 1'b0;
        m_aur_tready = 1'b1;  ctrl_loopback = 1'b0; ctrl_seq_en = 1'b1;
        idle(3);
        check("rst_host_tready", s_host_tready, 0);
        check("rst_aur_tvalid", m_aur_tvalid, 0);
        check("rst_host_tvalid", m_host_tvalid, 0);
        check("rst_tx_frames", stat_tx_frames, 0);
        check("rst_loop_active", stat_loop_active, 0);
        rst_n = 1'b1;
        idle(1);

        // 1: sequence insert, zero-latency passthrough, counter start at 0
        host_beat(a_w, 1'b0);
        check("t1_pass_data", {m_aur_tvalid, m_aur_tdata}, {1'b1, a_w});
        host_beat(b_w, 1'b0);
        host_beat(c_w, 1'b1);
        check("t1_tlast_forced", m_aur_tlast, 0);
        host_beat(e_w, 1'b1);
        host_idle();
        idle(4);
        exp_aur(1'b0, a_w); exp_aur(1'b0, b_w); exp_aur(1'b0, c_w); exp_aur(1'b1, 32'h0);
        exp_aur(1'b0, e_w); exp_aur(1'b1, 32'h1);
        check_aur("t1_aur");
        check("t1_tx_frames", stat_tx_frames, 2);

        // 2: RX strip with one-beat hold
        rx_beat(d0, 1'b0);
        rx_beat(d1, 1'b0);
        check("t2_hold_latency", m_host_tvalid, 0);
        rx_beat(d2, 1'b0);
        check("t2_first_out", {m_host_tvalid, m_host_tdata}, {1'b1, d0});
        rx_beat(32'h0000_002A, 1'b1);
        rx_idle();
        idle(3);
        exp_host(1'b0, d0); exp_host(1'b0, d1); exp_host(1'b1, d2);
        check_host("t2_host");
        check("t2_rx_seq", stat_rx_seq, 8'h2A);
        check("t2_rx_frames", stat_rx_frames, 1);

        // 2b: RX registered passthrough with sequencing disabled
        ctrl_seq_en = 1'b0;
        rx_beat(x0, 1'b0);
        rx_beat(x1, 1'b1);
        rx_idle();
        idle(2);
        exp_host(1'b0, x0); exp_host(1'b1, x1);
        check_host("t2b_host");
        check("t2b_rx_frames", stat_rx_frames, 2);
        ctrl_seq_en = 1'b1;

        // 3: loopback request mid-frame waits for the sequence word
        host_beat(32'h4800_0000, 1'b0);
        host_beat(32'h4800_0001, 1'b0);
        ctrl_loopback = 1'b1;
        host_beat(32'h4800_0002, 1'b0);
        host_beat(32'h4800_0003, 1'b0);
        host_beat(32'h4800_0004, 1'b1);
        check("t3_not_yet_loop", stat_loop_active, 0);
        host_idle();
        idle(4);
        for (int i = 0; i < 5; i++) exp_aur(1'b0, 32'h4800_0000 + 32'(i));
        exp_aur(1'b1, 32'h2);
        check_aur("t3_aur");
        check("t3_loop_active", stat_loop_active, 1);
        check("t3_tx_frames", stat_tx_frames, 3);
        @(negedge clk);
        s_host_tvalid = 1'b1;
        #2;
        check("t3_host_blocked", s_host_tready, 0);
        host_idle();

        // 4: loopback FIFO overflow, rest of frame dropped
        m_aur_tready = 1'b0;
        for (int i = 0; i < 20; i++) rx_beat(32'h100 + 32'(i), i == 19);
        rx_idle();
        idle(2);
        for (int i = 0; i < 19; i++) exp_host(i == 18, 32'h100 + 32'(i));
        check_host("t4_host");
        check("t4_ovf", stat_loop_ovf, 1);
        check("t4_head", {m_aur_tvalid, m_aur_tlast, m_aur_tdata}, {2'b10, 32'h100});
        check("t4_rx_seq", stat_rx_seq, 8'h13);
        check("t4_rx_frames", stat_rx_frames, 3);
        ctrl_loopback = 1'b0;
        m_aur_tready  = 1'b1;
        idle(20);
        for (int i = 0; i < 16; i++) exp_aur(1'b0, 32'h100 + 32'(i));
        check_aur("t4_drain");
        check("t4_loop_exit", stat_loop_active, 0);

        // 4b: verbatim loopback frame
        ctrl_loopback = 1'b1;
        idle(2);
        rx_beat(v0, 1'b0);
        rx_beat(v1, 1'b1);
        rx_idle();
        idle(4);
        exp_aur(1'b0, v0); exp_aur(1'b1, v1);
        check_aur("t4b_aur");
        exp_host(1'b1, v0);
        check_host("t4b_host");
        check("t4b_rx_seq", stat_rx_seq, 8'h14);
        ctrl_loopback = 1'b0;
        idle(2);
        check("t4b_loop_exit", stat_loop_active, 0);

        // 5: 8-bit sequence wrap 0xFE, 0xFF, 0x00
        for (int i = 0; i < 251; i++) host_beat(32'(i), 1'b1);
        host_idle();
        idle(3);
        aur_q.delete();
        host_beat(32'hF000_0000, 1'b1);
        host_beat(32'hF000_0001, 1'b1);
        host_beat(32'hF000_0002, 1'b1);
        host_idle();
        idle(3);
        exp_aur(1'b0, 32'hF000_0000); exp_aur(1'b1, 32'hFE);
        exp_aur(1'b0, 32'hF000_0001); exp_aur(1'b1, 32'hFF);
        exp_aur(1'b0, 32'hF000_0002); exp_aur(1'b1, 32'h00);
        check_aur("t5_wrap");
        check("t5_tx_frames", stat_tx_frames, 257);

        // 6: reset mid-frame, then a runt RX frame
        host_beat(m0, 1'b0);
        rx_beat(r0, 1'b0);
        s_host_tvalid = 1'b0;
        @(negedge clk);
        s_host_tvalid = 1'b1;
        m_aur_tready  = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t6_host_tready", s_host_tready, 0);
        check("t6_aur", {m_aur_tvalid, m_aur_tlast, m_aur_tdata}, 0);
        check("t6_host_out", {m_host_tvalid, m_host_tlast, m_host_tdata}, 0);
        check("t6_tx_frames", stat_tx_frames, 0);
        check("t6_rx_frames", stat_rx_frames, 0);
        check("t6_rx_seq", stat_rx_seq, 0);
        check("t6_flags", {stat_loop_ovf, stat_runt, stat_loop_active}, 0);
        idle(2);
        rst_n = 1'b1;
        s_host_tvalid = 1'b0;
        s_aur_tvalid  = 1'b0;
        aur_q.delete();
        host_q.delete();
        idle(1);
        rx_beat(s0, 1'b1);
        rx_idle();
        idle(3);
        check("t6_runt", stat_runt, 1);
        check("t6_no_host", host_q.size(), 0);
        check("t6_no_aur", aur_q.size(), 0);
        check("t6_runt_frames", stat_rx_frames, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
